// File: rtl/exec_wb_stage_if.sv
// rtl/exec_wb_stage_if.sv - instruction, register-file and status bundle for exec_wb_stage
interface exec_wb_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;

  // Decoder and register file side
  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, rdata1, rdata2,
    input  in_ready, raddr1, raddr2, rf_we, rf_waddr, rf_wdata, busy
  );

  // Execute/write-back stage side
  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, rdata1, rdata2,
    output in_ready, raddr1, raddr2, rf_we, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/exec_wb_stage.sv
// rtl/exec_wb_stage.sv - two-stage EX/WB ALU pipeline with hazard stall or operand bypass (EXEC_WB_BYPASS_EN)
module exec_wb_stage (
  input  logic           clk,
  input  logic           rst,
  exec_wb_stage_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // EX register
  logic        ex_valid_q, ex_valid_d;
  logic [2:0]  ex_op_q,    ex_op_d;
  logic [4:0]  ex_rd_q,    ex_rd_d;
  logic [31:0] ex_a_q,     ex_a_d;
  logic [31:0] ex_b_q,     ex_b_d;

  // WB register; rf_waddr/rf_wdata only move for entries that really write
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q,    wb_rd_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;

  logic [31:0] alu_result;
  logic        ex_live;
  logic        wb_live;
  logic        ex_hit1, ex_hit2, wb_hit1, wb_hit2;
  logic        stall;
  logic        in_ready;
  logic        accept;
  logic [31:0] op_a;
  logic [31:0] op_b;

  // Register-file read ports follow the presented sources directly
  assign bus.raddr1 = bus.in_rs1;
  assign bus.raddr2 = bus.in_rs2;

  // ALU on the EX operands; shifts use only the low five bits of op2
  always_comb begin
    alu_result = 32'd0;
    case (ex_op_q)
      OP_ADD:  alu_result = ex_a_q + ex_b_q;
      OP_SUB:  alu_result = ex_a_q - ex_b_q;
      OP_AND:  alu_result = ex_a_q & ex_b_q;
      OP_OR:   alu_result = ex_a_q | ex_b_q;
      OP_XOR:  alu_result = ex_a_q ^ ex_b_q;
      OP_SLL:  alu_result = ex_a_q << ex_b_q[4:0];
      OP_SRL:  alu_result = ex_a_q >> ex_b_q[4:0];
      OP_SLT:  alu_result = {31'd0, ($signed(ex_a_q) < $signed(ex_b_q))};
      default: alu_result = 32'd0;
    endcase
  end

  // An entry only matters for dependencies if it will write a non-zero register
  assign ex_live = ex_valid_q && (ex_rd_q != 5'd0);
  assign wb_live = wb_valid_q && (wb_rd_q != 5'd0);
  assign ex_hit1 = ex_live && (ex_rd_q == bus.in_rs1);
  assign ex_hit2 = ex_live && (ex_rd_q == bus.in_rs2);
  assign wb_hit1 = wb_live && (wb_rd_q == bus.in_rs1);
  assign wb_hit2 = wb_live && (wb_rd_q == bus.in_rs2);

  // Operand selection: forward (youngest producer first) or stall until the file is current
  always_comb begin
    stall = 1'b0;
    op_a  = bus.rdata1;
    op_b  = bus.rdata2;
`ifdef EXEC_WB_BYPASS_EN
    if (ex_hit1) begin
      op_a = alu_result;
    end else if (wb_hit1) begin
      op_a = rf_wdata_q;
    end
    if (ex_hit2) begin
      op_b = alu_result;
    end else if (wb_hit2) begin
      op_b = rf_wdata_q;
    end
`else
    stall = ex_hit1 || ex_hit2 || wb_hit1 || wb_hit2;
`endif
  end

  // Ready stays high while in reset; nothing is taken on a reset edge
  assign in_ready     = rst || !stall;
  assign bus.in_ready = in_ready;
  assign accept       = bus.in_valid && in_ready && !rst;

  // Next-state for both pipeline registers
  always_comb begin
    ex_valid_d = accept;
    ex_op_d    = ex_op_q;
    ex_rd_d    = ex_rd_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    wb_valid_d = ex_valid_q;
    wb_rd_d    = ex_rd_q;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (accept) begin
      ex_op_d = bus.in_op;
      ex_rd_d = bus.in_rd;
      ex_a_d  = op_a;
      ex_b_d  = op_b;
    end
    if (ex_live) begin
      rf_waddr_d = ex_rd_q;
      rf_wdata_d = alu_result;
    end
  end

  // Pipeline state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= 3'd0;
      ex_rd_q    <= 5'd0;
      ex_a_q     <= 32'd0;
      ex_b_q     <= 32'd0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_rd_q    <= ex_rd_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // A write pending during a reset cycle is suppressed so the dropped entry never lands
  assign bus.rf_we    = wb_live && !rst;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.busy     = ex_valid_q || wb_valid_q;

endmodule

// File: tb/tb_exec_wb_stage.sv
// tb/tb_exec_wb_stage.sv - randomized model-checked bench for exec_wb_stage
module tb_exec_wb_stage;

  logic clk = 1'b0;
  logic rst;
  exec_wb_stage_if bus();

  exec_wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Environment register file, written only by the DUT's write port
  logic [31:0] env_rf [32];
  assign bus.rdata1 = (bus.raddr1 == 5'd0) ? 32'd0 : env_rf[bus.raddr1];
  assign bus.rdata2 = (bus.raddr2 == 5'd0) ? 32'd0 : env_rf[bus.raddr2];

  // Model state: architectural file, program-order file, in-flight list
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          age;
  } ent_t;

  ent_t        pq[$];
  logic [31:0] arch_rf [32];
  logic [31:0] spec_rf [32];
  logic [4:0]  last_waddr = 5'd0;
  logic [31:0] last_wdata = 32'd0;
  logic        acc_next = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << (b % 32);
      3'd6: return a >> (b % 32);
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Register file initial contents and the DUT-driven write port
  initial begin
    for (int i = 0; i < 32; i++) env_rf[i] = 32'd0;
    env_rf[1] = 32'd5;
    env_rf[2] = 32'd7;
    env_rf[5] = 32'd1;
    env_rf[6] = 32'hFFFF_FFFF;
    env_rf[7] = 32'h8000_0000;
    env_rf[8] = 32'd31;
    env_rf[9] = 32'd33;
    arch_rf = env_rf;
    spec_rf = env_rf;
    forever begin
      @(posedge clk);
      if (bus.rf_we === 1'b1 && bus.rf_waddr != 5'd0) env_rf[bus.rf_waddr] <= bus.rf_wdata;
    end
  end

  // Compare process: check every cycle, then advance the model across the next edge
  initial begin
    logic        exp_we;
    logic        exp_busy;
    logic        exp_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    ent_t        nq[$];
    ent_t        e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_we    = 1'b0;
      exp_busy  = (pq.size() != 0);
      exp_ready = 1'b1;
      foreach (pq[i]) if (pq[i].age == 2 && pq[i].rd != 5'd0 && !rst) exp_we = 1'b1;
`ifndef EXEC_WB_BYPASS_EN
      if (!rst)
        foreach (pq[i])
          if (pq[i].rd != 5'd0 && (pq[i].rd == bus.in_rs1 || pq[i].rd == bus.in_rs2)) exp_ready = 1'b0;
`endif
      chk("rf_we", bus.rf_we, exp_we);
      chk("busy", bus.busy, exp_busy);
      chk("in_ready", bus.in_ready, exp_ready);
      chk("raddr1", bus.raddr1, bus.in_rs1);
      chk("raddr2", bus.raddr2, bus.in_rs2);
      chk("rf_waddr", bus.rf_waddr, last_waddr);
      chk("rf_wdata", bus.rf_wdata, last_wdata);

      if (rst) begin
        pq.delete();
        spec_rf    = arch_rf;
        last_waddr = 5'd0;
        last_wdata = 32'd0;
        acc_next   = 1'b0;
      end else begin
        acc_next = bus.in_valid && exp_ready;
        nq.delete();
        foreach (pq[i]) begin
          e = pq[i];
          if (e.age == 2) begin
            if (e.rd != 5'd0) arch_rf[e.rd] = e.data;
          end else begin
            e.age = e.age + 1;
            if (e.rd != 5'd0) begin
              last_waddr = e.rd;
              last_wdata = e.data;
            end
            nq.push_back(e);
          end
        end
        pq = nq;
        if (acc_next) begin
          a = (bus.in_rs1 == 5'd0) ? 32'd0 : spec_rf[bus.in_rs1];
          b = (bus.in_rs2 == 5'd0) ? 32'd0 : spec_rf[bus.in_rs2];
          r = alu(bus.in_op, a, b);
          if (bus.in_rd != 5'd0) spec_rf[bus.in_rd] = r;
          e.rd   = bus.in_rd;
          e.data = r;
          e.age  = 1;
          pq.push_back(e);
        end
      end
    end
  end

  // Present one instruction until the model says it is taken; count not-ready cycles seen
  task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, output int stalls);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    stalls       = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b1) stalls++;
      @(posedge clk);
      if (acc_next) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got no accept expected accept within 20 cycles at %0t", $time);
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    int s2;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op    = 3'd0;
    bus.in_rd    = 5'd10;
    bus.in_rs1   = 5'd1;
    bus.in_rs2   = 5'd2;

    // Two reset cycles with an instruction presented
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_rf_we", bus.rf_we, 1'b0);
    chk("reset_ready", bus.in_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_accept_after_release", bus.busy, 1'b1);
    bus.in_valid = 1'b0;
    drain();

    // ADD x3 = 5 + 7 visible on the write port two cycles after accept
    issue(3'd0, 5'd3, 5'd1, 5'd2, s);
    @(posedge clk);
    @(negedge clk);
    chk("add_rf_we", bus.rf_we, 1'b1);
    chk("add_waddr", bus.rf_waddr, 32'd3);
    chk("add_wdata", bus.rf_wdata, 32'd12);
    drain();

    // Back-to-back dependency
    issue(3'd0, 5'd3, 5'd1, 5'd2, s);
    issue(3'd1, 5'd4, 5'd3, 5'd1, s2);
`ifdef EXEC_WB_BYPASS_EN
    chk("dep_stalls", s2, 32'd0);
`else
    chk("dep_stalls", s2, 32'd2);
`endif
    drain();

    // rd = 0 producer followed by an x0 reader
    issue(3'd3, 5'd0, 5'd1, 5'd2, s);
    issue(3'd0, 5'd13, 5'd0, 5'd1, s2);
    chk("x0_no_stall", s2, 32'd0);

    // Arithmetic corners
    issue(3'd1, 5'd14, 5'd0, 5'd5, s);
    issue(3'd7, 5'd15, 5'd6, 5'd5, s);
    issue(3'd6, 5'd16, 5'd7, 5'd8, s);
    issue(3'd5, 5'd17, 5'd5, 5'd9, s);
    drain();
    chk("x10_add", env_rf[10], 32'd12);
    chk("x3_add", env_rf[3], 32'd12);
    chk("x4_dep_sub", env_rf[4], 32'd7);
    chk("x13_x0_read", env_rf[13], 32'd5);
    chk("sub_wrap", env_rf[14], 32'hFFFF_FFFF);
    chk("slt_signed", env_rf[15], 32'd1);
    chk("srl_31", env_rf[16], 32'd1);
    chk("sll_33", env_rf[17], 32'd2);

    // Reset with one entry in WB and one in EX
    issue(3'd0, 5'd11, 5'd1, 5'd2, s);
    issue(3'd4, 5'd12, 5'd1, 5'd2, s);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("flush_busy", bus.busy, 1'b0);
    chk("flush_rf_we", bus.rf_we, 1'b0);
    drain();
    chk("flush_x11", env_rf[11], 32'd0);
    chk("flush_x12", env_rf[12], 32'd0);

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.in_rs1 = 5'($urandom_range(0, 7));
        bus.in_rs2 = 5'($urandom_range(0, 7));
        @(posedge clk);
        #1;
      end else begin
        issue(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), s);
      end
    end
    drain();
    for (int i = 1; i < 8; i++) chk("final_arch_reg", env_rf[i], arch_rf[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
